// File: rtl/spi_arb_pkg.sv
// Shared types and SPI bus idle levels for the SPI bus arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GUARD
  } arb_state_e;

  localparam logic SckIdle = 1'b0;
  localparam logic TxIdle  = 1'b0;
  localparam logic CsIdle  = 1'b1;

endpackage

// File: rtl/spi_bus_arbiter_rr.sv
// Combinational round-robin pick: first request at or after the pointer,
// wrapping at NumReq.
module rr_arbiter #(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  // Two descending sweeps where the last hit wins: wrapped candidates below
  // the pointer are overridden by any candidate at or after it.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = |req_i;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_i[i] && (i < int'(ptr_i))) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_i[i] && (i >= int'(ptr_i))) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between NumReq hosts: round-robin grants held until
// release, an idle guard between owners and a hold-time watchdog.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter  int unsigned NumReq        = 2,
  parameter  int unsigned CsNum         = 4,
  parameter  int unsigned GuardCycles   = 2,
  parameter  int unsigned TimeoutCycles = 65535,
  localparam int unsigned IdxW          = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic                    timeout_o,
  output logic [IdxW-1:0]         timeout_id_o,
  input  logic [NumReq-1:0]       req_sck_i,
  input  logic [NumReq-1:0]       req_tx_i,
  input  logic [NumReq*CsNum-1:0] req_cs_i,
  output logic [NumReq-1:0]       req_rx_o,
  output logic                    spi_sck_o,
  output logic                    spi_tx_o,
  output logic [CsNum-1:0]        spi_cs_o,
  input  logic                    spi_rx_i
);

  localparam int unsigned HoldW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int unsigned GuardW = $clog2(GuardCycles + 1);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [GuardW-1:0] GuardLast = GuardW'(GuardCycles - 1);

  arb_state_e        state_q, state_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [NumReq-1:0] mask_q, mask_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic              timeout_q, timeout_d;
  logic [IdxW-1:0]   timeout_id_q, timeout_id_d;
  logic [NumReq-1:0] revoke_set;
  logic [NumReq-1:0] pick_gnt;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_valid;
  logic              hold_hit;

  rr_arbiter #(
    .NumReq (NumReq)
  ) u_rr (
    .req_i   (req_i & ~mask_q),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign hold_hit = (TimeoutCycles != 0) && (hold_q == HoldLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      ptr_q        <= '0;
      mask_q       <= '0;
      hold_q       <= '0;
      guard_q      <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      mask_q       <= mask_d;
      hold_q       <= hold_d;
      guard_q      <= guard_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  // A release takes priority over a watchdog hit in the same cycle, so an
  // owner that lets go on its last allowed cycle is never flagged.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    hold_d       = hold_q;
    guard_d      = guard_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    revoke_set   = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          hold_d  = '0;
          ptr_d   = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      GRANT: begin
        if (!req_i[owner_q]) begin
          state_d = GUARD;
          gnt_d   = '0;
          guard_d = '0;
        end else if (hold_hit) begin
          state_d             = GUARD;
          gnt_d               = '0;
          guard_d             = '0;
          timeout_d           = 1'b1;
          timeout_id_d        = owner_q;
          revoke_set[owner_q] = 1'b1;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      GUARD: begin
        if (guard_q == GuardLast) begin
          state_d = IDLE;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    mask_d = (mask_q & req_i) | revoke_set;
  end

  // The registered grant alone selects the bus source, so nothing but the
  // current owner can ever reach the chip selects.
  always_comb begin
    spi_sck_o = SckIdle;
    spi_tx_o  = TxIdle;
    spi_cs_o  = {CsNum{CsIdle}};
    req_rx_o  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_q[i]) begin
        spi_sck_o   = req_sck_i[i];
        spi_tx_o    = req_tx_i[i];
        spi_cs_o    = req_cs_i[i*CsNum +: CsNum];
        req_rx_o[i] = spi_rx_i;
      end
    end
  end

  assign gnt_o        = gnt_q;
  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;

endmodule
